// File: rtl/mem_rd_sched_pkg.sv
// Shared definitions for the accumulator read scheduler: FSM states, geometry helpers
// and the read-enable pipeline drain depth.
package neurex_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    // Cycles the read-enable pipeline needs to empty after the controller stops.
    localparam int DRAIN_CYCLES = 3;

    function automatic int accum_row(input int accum_size, input int sys_col);
        return accum_size / sys_col;
    endfunction

    // Counter must hold 2*ACCUM_ROW + DRAIN_CYCLES.
    function automatic int timer_width(input int arow);
        return $clog2(2 * arow + DRAIN_CYCLES + 1);
    endfunction

endpackage

// File: rtl/mem_rd_sched_if.sv
// Command and read-start bundle between the scheduler and its host / read controller.
interface mem_rd_sched_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TILE_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base_addr;
    logic [DATA_WIDTH-1:0] cmd_num_row;
    logic [TILE_WIDTH-1:0] cmd_num_tile;
    logic [ADDR_WIDTH-1:0] cmd_stride;
    logic                  rd_en_in;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [DATA_WIDTH-1:0] num_row;
    logic                  busy;
    logic                  done;

    modport master (
        output cmd_valid, cmd_base_addr, cmd_num_row, cmd_num_tile, cmd_stride,
        input  cmd_ready, rd_en_in, base_addr, num_row, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_num_row, cmd_num_tile, cmd_stride,
        output cmd_ready, rd_en_in, base_addr, num_row, busy, done
    );
endinterface

// File: rtl/mem_rd_sched_timer.sv
// Loadable down-counter timing the read-controller run plus pipeline drain.
module rd_run_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_rd_sched.sv
// Splits a multi-tile accumulator read command into per-tile start pulses, spacing
// them by the controller run time plus drain, and signals completion once.
module mem_rd_sched
    import neurex_mem_pkg::*;
#(
    parameter int SYS_ROW    = 16,
    parameter int SYS_COL    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ACCUM_SIZE = 4096,
    parameter int ADDR_WIDTH = 16,
    parameter int TILE_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rstn,
    mem_rd_sched_if.slave  bus
);

    localparam int ACCUM_ROW = accum_row(ACCUM_SIZE, SYS_COL);
    localparam int TW        = timer_width(ACCUM_ROW);
    localparam logic [DATA_WIDTH-1:0] ROW_CAP = DATA_WIDTH'(ACCUM_ROW);

    if (SYS_ROW < 1 || (ACCUM_SIZE % SYS_COL) != 0) begin : g_bad_geometry
        $error("mem_rd_sched: inconsistent systolic/accumulator geometry");
    end

    sched_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, stride_q;
    logic [DATA_WIDTH-1:0] nr_q, nr_clamp;
    logic [TILE_WIDTH-1:0] tiles_q;
    logic [TW-1:0]         tmr_cnt, tmr_load_val;
    logic                  tmr_zero, accept, empty_cmd, last_tile;

    assign accept    = bus.cmd_valid && (state_q == IDLE);
    assign empty_cmd = (bus.cmd_num_row == '0) || (bus.cmd_num_tile == '0);
    assign nr_clamp  = (bus.cmd_num_row > ROW_CAP) ? ROW_CAP : bus.cmd_num_row;
    assign last_tile = (tiles_q == TILE_WIDTH'(1));

    // WAIT spans counts load_val..0, i.e. 2*rows + DRAIN_CYCLES cycles.
    assign tmr_load_val = TW'({nr_q, 1'b0}) + TW'(DRAIN_CYCLES - 1);

    rd_run_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (state_q == ISSUE),
        .load_val (tmr_load_val),
        .dec      (state_q == WAIT),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = empty_cmd ? DONE : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (tmr_zero) state_d = last_tile ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q   <= '1;
            stride_q <= '0;
            nr_q     <= '0;
            tiles_q  <= '0;
        end else if (accept) begin
            base_q   <= bus.cmd_base_addr;
            stride_q <= bus.cmd_stride;
            nr_q     <= nr_clamp;
            tiles_q  <= bus.cmd_num_tile;
        end else if (state_q == WAIT && tmr_zero && !last_tile) begin
            // Address wraps modulo 2^ADDR_WIDTH by construction.
            base_q  <= base_q + stride_q;
            tiles_q <= tiles_q - 1'b1;
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rd_en_in  = (state_q == ISSUE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.base_addr = base_q;
    assign bus.num_row   = nr_q;

endmodule

// File: tb/tb_mem_rd_sched.sv
// Self-checking bench for mem_rd_sched: directed corner commands plus random commands
// checked cycle by cycle against a timing model derived from the command fields.
module tb_mem_rd_sched;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TW = 8;
    localparam int ACC_ROW = 256;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mem_rd_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TILE_WIDTH(TW)) bus ();

    mem_rd_sched #(
        .SYS_ROW(16), .SYS_COL(16), .DATA_WIDTH(DW),
        .ACCUM_SIZE(4096), .ADDR_WIDTH(AW), .TILE_WIDTH(TW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_drive();
        bus.cmd_valid     = 1'b0;
        bus.cmd_base_addr = '0;
        bus.cmd_num_row   = '0;
        bus.cmd_num_tile  = '0;
        bus.cmd_stride    = '0;
    endtask

    task automatic noise_drive();
        bus.cmd_valid     = 1'($urandom);
        bus.cmd_base_addr = AW'($urandom);
        bus.cmd_num_row   = DW'($urandom);
        bus.cmd_num_tile  = TW'($urandom);
        bus.cmd_stride    = AW'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_en"}, bus.rd_en_in, 1'b0);
        chk({tag, "_done"},  bus.done, 1'b0);
        chk({tag, "_busy"},  bus.busy, 1'b0);
        chk({tag, "_ready"}, bus.cmd_ready, 1'b1);
        chk({tag, "_base"},  bus.base_addr, 16'hFFFF);
        chk({tag, "_nrow"},  bus.num_row, 16'd0);
    endtask

    // Called at a negedge with the DUT idle. Observation j is the j-th negedge after
    // the accepting edge: tile k pulses at j = 1 + k*(2*rows+4), done at tiles*(2*rows+4)+1.
    task automatic run_cmd(input logic [15:0] b, input logic [15:0] nr, input logic [7:0] nt,
                           input logic [15:0] st, input bit noise);
        int clamp, per, total, tile;
        bit zero_cmd, exp_pulse, exp_busy;
        logic [15:0] exp_addr;
        clamp    = (int'(nr) > ACC_ROW) ? ACC_ROW : int'(nr);
        per      = 2 * clamp + 4;
        zero_cmd = (nr == 0) || (nt == 0);
        total    = zero_cmd ? 1 : int'(nt) * per + 1;
        chk("ready_pre", bus.cmd_ready, 1'b1);
        bus.cmd_valid     = 1'b1;
        bus.cmd_base_addr = b;
        bus.cmd_num_row   = nr;
        bus.cmd_num_tile  = nt;
        bus.cmd_stride    = st;
        @(posedge clk);
        for (int j = 1; j <= total + 1; j++) begin
            @(negedge clk);
            exp_busy  = (j <= total);
            exp_pulse = !zero_cmd && (j < total) && ((j - 1) % per == 0);
            tile      = zero_cmd ? 0 : (j - 1) / per;
            chk("rd_en", bus.rd_en_in, exp_pulse);
            chk("done",  bus.done, j == total);
            chk("busy",  bus.busy, exp_busy);
            chk("ready", bus.cmd_ready, !exp_busy);
            if (exp_pulse) begin
                exp_addr = 16'(int'(b) + tile * int'(st));
                chk("base_addr", bus.base_addr, exp_addr);
            end
            if (!zero_cmd && j < total)
                chk("num_row", bus.num_row, 16'(clamp));
            if (j == total + 1) begin
                exp_addr = zero_cmd ? b : 16'(int'(b) + (int'(nt) - 1) * int'(st));
                chk("base_hold", bus.base_addr, exp_addr);
            end
            if (noise && j < total) noise_drive();
            else                    idle_drive();
        end
    endtask

    initial begin
        logic [15:0] rb, rn, rs;
        logic [7:0]  rt;
        rstn = 1'b0;
        idle_drive();
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.cmd_ready, 1'b1);

        run_cmd(16'h0100, 16'd4,   8'd1, 16'h0000, 1'b0);
        run_cmd(16'h0000, 16'd8,   8'd3, 16'h0040, 1'b0);
        run_cmd(16'h0200, 16'd300, 8'd1, 16'h0010, 1'b0);
        run_cmd(16'h0300, 16'd0,   8'd2, 16'h0008, 1'b0);
        run_cmd(16'h0400, 16'd5,   8'd0, 16'h0008, 1'b0);
        run_cmd(16'hFFF0, 16'd3,   8'd2, 16'h0020, 1'b0);
        run_cmd(16'h0500, 16'd6,   8'd3, 16'h0100, 1'b1);

        // Reset in the middle of the first tile's WAIT window.
        bus.cmd_valid     = 1'b1;
        bus.cmd_base_addr = 16'h1234;
        bus.cmd_num_row   = 16'd8;
        bus.cmd_num_tile  = 8'd2;
        bus.cmd_stride    = 16'h0010;
        @(posedge clk);
        repeat (5) @(negedge clk);
        idle_drive();
        chk("mid_busy", bus.busy, 1'b1);
        #2 rstn = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", bus.done, 1'b0);
            chk("rst_no_busy", bus.busy, 1'b0);
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_post_rst", bus.cmd_ready, 1'b1);
        run_cmd(16'h0800, 16'd2, 8'd2, 16'h0004, 1'b1);

        for (int i = 0; i < 30; i++) begin
            rb = 16'($urandom);
            rs = 16'($urandom);
            rn = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(257, 400))
                                             : 16'($urandom_range(0, 12));
            rt = (rn > 16'd256) ? 8'd1 : 8'($urandom_range(0, 4));
            run_cmd(rb, rn, rt, rs, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_rd_sched.md
MEM_RD_SCHED -- requirements
Module: mem_rd_sched

Interface
REQ-001 SHALL have parameter SYS_ROW, default 16, systolic rows; used only for documentation consistency.
REQ-002 SHALL have parameter SYS_COL, default 16, systolic columns.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, width of row counts.
REQ-004 SHALL have parameter ACCUM_SIZE, default 4096, accumulator entries; ACCUM_ROW = ACCUM_SIZE/SYS_COL.
REQ-005 SHALL have parameter ADDR_WIDTH, default 16, accumulator address width.
REQ-006 SHALL have parameter TILE_WIDTH, default 8, width of tile count.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port cmd_valid  input  1  command offered.
REQ-010 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-011 SHALL have port cmd_base_addr  input  ADDR_WIDTH  first tile base address.
REQ-012 SHALL have port cmd_num_row  input  DATA_WIDTH  rows per tile.
REQ-013 SHALL have port cmd_num_tile  input  TILE_WIDTH  tiles in command.
REQ-014 SHALL have port cmd_stride  input  ADDR_WIDTH  address step between tiles.
REQ-015 SHALL have port rd_en_in  output  1  one-cycle start pulse to read controller.
REQ-016 SHALL have port base_addr  output  ADDR_WIDTH  current tile base address.
REQ-017 SHALL have port num_row  output  DATA_WIDTH  clamped row count for current tile.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-019 SHALL have port done  output  1  one-cycle pulse at command completion.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; cmd_ready = (state==IDLE).
REQ-021 On cmd_valid&&cmd_ready SHALL capture all cmd_* fields and go to ISSUE, or to DONE if cmd_num_row==0 or cmd_num_tile==0 (no pulse issued).
REQ-022 num_row output SHALL equal min(captured num_row, ACCUM_ROW) and stay stable from ISSUE through the last WAIT cycle of the command.
REQ-023 In ISSUE rd_en_in SHALL be 1 for exactly one cycle with base_addr = captured base + tile_idx*stride, modulo 2^ADDR_WIDTH (wrap, no saturation); next state WAIT.
REQ-024 WAIT SHALL last exactly L+3 cycles, L = 2*num_row (clamped), covering controller run plus 3-cycle drain of the read-enable pipeline.
REQ-025 Leaving WAIT SHALL go to ISSUE with base_addr += stride if tiles remain, else DONE.
REQ-026 DONE SHALL last one cycle with done=1, then IDLE; latency single tile: accept at cycle a, pulse at a+1, done at a+L+5, cmd_ready at a+L+6.
REQ-027 base_addr SHALL hold its last value in IDLE; rd_en_in SHALL be 0 outside ISSUE.
REQ-028 cmd_valid while busy SHALL be ignored (not captured, no side effect).
REQ-029 WAIT counter SHALL be wide enough for 2*ACCUM_ROW+3 without overflow.

Reset
REQ-030 rstn low SHALL asynchronously force IDLE, rd_en_in=0, done=0, busy=0, base_addr=all ones, num_row=0, counters=0.
REQ-031 Reset mid-command SHALL abandon the command with no done pulse; first cycle after release cmd_ready=1.

Structure
REQ-032 State enum, ACCUM_ROW computation and DRAIN_CYCLES=3 SHALL live in shared package neurex_mem_pkg.
REQ-033 Sub-module SHALL be one: rd_run_timer (loadable down-counter with zero flag); integration top instantiates mem_rd_sched beside the read controller.

Verification (SYS_COL=16, ACCUM_SIZE=4096, ACCUM_ROW=256)
REQ-034 One tile, base=0x0100, num_row=4 -> one rd_en_in pulse at a+1 with base_addr=0x0100, done at a+13.
REQ-035 Three tiles, base=0x0000, stride=0x0040, num_row=8 -> pulses 20 cycles apart with base_addr 0x0000, 0x0040, 0x0080; single done.
REQ-036 num_row=300 -> num_row output 256, WAIT 515 cycles; num_row=0 or num_tile=0 -> no pulse, done at a+1.
REQ-037 base=0xFFF0, stride=0x0020, 2 tiles -> second base_addr 0x0010 (wrap).
REQ-038 rstn asserted mid-WAIT -> outputs at reset values immediately, no done; new command accepted after release.
REQ-039 cmd_valid held high during busy with changing fields -> no capture, current tile addresses unaffected.
